// File: rtl/lfo_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lfo_phase_scheduler
// Purpose  : Shares one sine-table BRAM between several chorus LFO voices,
//            advancing per-voice phases once per audio sample tick.
// Revision : 1.0
// ============================================================================
module lfo_phase_scheduler #(
    parameter int SIZE   = 44100,
    parameter int VOICES = 3
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  enable_i,
    input  logic                  sample_tick_i,
    input  logic                  step_wr_i,
    input  logic [1:0]            step_sel_i,
    input  logic [15:0]           step_in_i,
    output logic [15:0]           lut_addr_o,
    input  logic [15:0]           lut_data_i,
    output logic [16*VOICES-1:0]  voice_data_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [16:0] SIZE_W = 17'(SIZE);

    function automatic logic [15:0] init_phase(input int idx);
        return 16'(idx * (SIZE / VOICES));
    endfunction

    state_t                 state_q, state_d;
    logic [1:0]             voice_q, voice_d;
    logic [15:0]            phase_q [VOICES];
    logic [15:0]            phase_d [VOICES];
    logic [15:0]            step_q  [VOICES];
    logic [15:0]            step_d  [VOICES];
    logic [15:0]            lut_addr_q, lut_addr_d;
    logic [16*VOICES-1:0]   voice_data_q, voice_data_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    logic [15:0]            cur_phase;
    logic [15:0]            cur_step;
    logic [16:0]            phase_sum;
    logic [15:0]            phase_adv;

    // Phase + step never exceeds 2*SIZE-2, so one conditional subtract wraps it.
    always_comb begin
        cur_phase = '0;
        cur_step  = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (i == int'(voice_q)) begin
                cur_phase = phase_q[i];
                cur_step  = step_q[i];
            end
        end
        phase_sum = {1'b0, cur_phase} + {1'b0, cur_step};
        phase_adv = (phase_sum >= SIZE_W) ? 16'(phase_sum - SIZE_W) : phase_sum[15:0];
    end

    always_comb begin
        state_d      = state_q;
        voice_d      = voice_q;
        phase_d      = phase_q;
        step_d       = step_q;
        lut_addr_d   = lut_addr_q;
        voice_data_d = voice_data_q;
        valid_d      = 1'b0;
        busy_d       = busy_q;

        if (step_wr_i && (int'(step_sel_i) < VOICES) && (int'(step_in_i) < SIZE)) begin
            for (int i = 0; i < VOICES; i++) begin
                if (i == int'(step_sel_i)) begin
                    step_d[i] = step_in_i;
                end
            end
        end

        if (!enable_i) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                phase_d[i] = init_phase(i);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample_tick_i) begin
                        state_d    = ISSUE;
                        voice_d    = 2'd0;
                        lut_addr_d = phase_q[0];
                        busy_d     = 1'b1;
                    end
                end
                ISSUE: begin
                    // Data returning now belongs to the address issued last cycle.
                    for (int i = 0; i < VOICES; i++) begin
                        if (i == int'(voice_q)) begin
                            phase_d[i] = phase_adv;
                        end
                        if (i + 1 == int'(voice_q)) begin
                            voice_data_d[16*i +: 16] = lut_data_i;
                        end
                        if (i == int'(voice_q) + 1) begin
                            lut_addr_d = phase_q[i];
                        end
                    end
                    if (int'(voice_q) < VOICES - 1) begin
                        voice_d = voice_q + 2'd1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    voice_data_d[16*(VOICES-1) +: 16] = lut_data_i;
                    state_d = DONE;
                    valid_d = 1'b1;
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= IDLE;
            voice_q      <= 2'd0;
            lut_addr_q   <= '0;
            voice_data_q <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                phase_q[i] <= init_phase(i);
                step_q[i]  <= 16'd1;
            end
        end else begin
            state_q      <= state_d;
            voice_q      <= voice_d;
            lut_addr_q   <= lut_addr_d;
            voice_data_q <= voice_data_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            phase_q      <= phase_d;
            step_q       <= step_d;
        end
    end

    assign lut_addr_o   = lut_addr_q;
    assign voice_data_o = voice_data_q;
    assign valid_o      = valid_q;
    assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: doc/lfo_phase_scheduler.md
# lfo_phase_scheduler

Time-multiplexes a single sine-table BRAM (16-bit address, 16-bit data, one-cycle registered read) between several chorus LFO voices. On each audio sample tick it advances one phase accumulator per voice by a programmable step, modulo the table size. It then issues one table read per voice back-to-back and captures the returned sine values into per-voice output registers. It sits between the sample-rate strobe and the chorus delay-modulation logic, replacing one free-running LUT counter per voice.

## Interface
- SIZE, 44100: number of table entries; legal phase range 0..SIZE-1.
- VOICES, 3: number of LFO voices (2..4).
- clk  in  1  system clock, all logic rising-edge.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  scheduler run enable; low forces idle and phase re-init.
- sample_tick  in  1  one-cycle strobe per audio sample, starts a pass.
- step_wr  in  1  write strobe for a per-voice phase step.
- step_sel  in  2  voice index for step_wr; values >= VOICES are ignored.
- step_in  in  16  phase increment, in table entries per sample.
- lut_addr  out  16  registered read address to the sine BRAM.
- lut_data  in  16  BRAM read data, valid the cycle after lut_addr is presented.
- voice_data  out  16*VOICES  captured sine value per voice; voice i occupies bits [16i+15:16i].
- valid  out  1  one-cycle pulse when all voice_data for the pass are updated.
- busy  out  1  high while a pass is in progress.

## Operation
- Reset (async, resetn low) clears the following:
  - lut_addr, voice_data, valid and busy to 0.
  - step[i] to 1.
  - phase[i] to i*(SIZE/VOICES), using integer division. For the defaults this gives 0, 14700, 29400.
- Step writes:
  - When step_wr=1, step_sel<VOICES and step_in<SIZE, step[step_sel] updates at the edge.
  - A write with step_in>=SIZE is ignored.
  - Writes are accepted in any state.
- The FSM has four states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: sample_tick=1 and enable=1 → ISSUE with voice index v=0. lut_addr <= phase[0] at that edge.
  - ISSUE (v = 0..VOICES-1): lut_addr holds phase[v]. At the end of the cycle:
    - phase[v] <= (phase[v]+step[v]) mod SIZE.
    - voice_data[v-1] <= lut_data when v>0.
    - If v<VOICES-1, lut_addr <= phase[v+1] and v increments; otherwise go to DRAIN.
  - DRAIN: voice_data[VOICES-1] <= lut_data, then go to DONE.
  - DONE: valid=1 for this cycle only, then go to IDLE.
- Modular add:
  - Computed at 17 bits: sum = phase+step. The result is sum-SIZE if sum>=SIZE, else sum.
  - The result is always in 0..SIZE-1, so no address ever reaches SIZE or more.
- The advance uses the step register value present during the voice's ISSUE cycle. A step write landing on that same edge takes effect on the next pass.
- sample_tick in any state other than IDLE is dropped: it is neither queued nor counted.
- enable=0 in any state: at the next edge the FSM goes to IDLE, all phases reload their reset offsets, and busy and valid go to 0.
  - voice_data, step and lut_addr hold their values.
  - A pass aborted this way produces no valid pulse.
- busy=1 in ISSUE, DRAIN and DONE; busy=0 in IDLE.
- voice_data changes only at capture edges. Between passes it holds its value.

## Timing
- sample_tick sampled high at edge of cycle T (FSM in IDLE):
  - lut_addr = phase[i] during cycle T+1+i.
  - voice_data[i] updates and becomes visible from cycle T+3+i.
  - valid is high during cycle T+2+VOICES (T+5 for the defaults).
- The pass occupies VOICES+2 cycles (5 for the defaults). The earliest next accepted tick is cycle T+3+VOICES.
- BRAM latency is fixed at one cycle. lut_data is sampled exactly one cycle after the matching lut_addr.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset then first pass: release resetn, leave steps at 1, pulse sample_tick.
  - Required: lut_addr sequence 0, 14700, 29400 on consecutive cycles.
  - Required: voice_data equals the table contents at those addresses.
  - Required: valid pulses exactly 5 cycles after the tick; phases become 1, 14701, 29401.
- Wrap-around: write step[2]=20000 (phase[2]=29400), run 2 passes.
  - Required: addresses presented for voice 2 are 29400, then 5300.
  - Required: phase[2] is 25300 afterwards and never reaches 44100 or more.
- Step write validation: write step_in=44100 to voice 0 and step_sel=3 with step_in=5.
  - Required: both writes ignored; voice 0 still advances by 1 per pass.
- Tick while busy: pulse sample_tick at T and again at T+2.
  - Required: only one pass runs and one valid pulse occurs.
  - Required: a tick at T+6 starts a second pass.
- enable drop mid-pass: deassert enable at cycle T+2.
  - Required: FSM in IDLE with busy=0 next cycle and no valid pulse.
  - Required: phases reload to 0/14700/29400; voice_data keeps its prior values.
- Async reset mid-pass: assert resetn low between clock edges at T+3.
  - Required: all outputs read 0 immediately, without waiting for a clock edge.
  - Required: after release, the first pass restarts from 0, 14700, 29400.
